// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
//   sched_state_t : scheduler FSM states
//   POS_ACK       : standard acknowledge byte used by requesters
//   clog2_min1()  : index width helper that never returns 0
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, ACK} sched_state_t;

  localparam logic [7:0] POS_ACK = 8'hA5;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request bit, searching upward from rr_ptr with wrap-around.
//   req    : request vector
//   rr_ptr : index that has the highest priority this round
//   grant  : index of the chosen requester (0 when nothing is requested)
//   valid  : at least one request is set
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   grant,
  output logic            valid
);

  always_comb begin
    int          idx;
    logic [IW-1:0] idx_t;
    idx   = 0;
    idx_t = '0;
    grant = '0;
    valid = |req;
    // Walk from the farthest offset back to rr_ptr so the closest match
    // (lowest offset from rr_ptr) is the last assignment and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_t = IW'(idx);
      if (req[idx_t]) grant = idx_t;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one byte-serial UART transmitter among NREQ requesters.
// A granted requester's word is captured, sent MSB byte first (one trmt pulse
// per byte, waiting for tx_done between bytes), then acknowledged.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request level, held until ack
//   req_data   : packed words, requester i at [i*8*NBYTES +: 8*NBYTES]
//   ack        : one-cycle pulse to the requester whose word finished
//   busy       : high from grant until ack
//   trmt       : one-cycle start pulse to the transmitter
//   tx_data    : byte to transmit, valid with trmt and held until next trmt
//   tx_done    : transmitter done level (cleared by the cycle after trmt)
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int NBYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*8*NBYTES-1:0] req_data,
  output logic [NREQ-1:0]          ack,
  output logic                     busy,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  input  logic                     tx_done
);

  localparam int WW = 8 * NBYTES;
  localparam int IW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(NBYTES);

  sched_state_t    state_reg, state_next;
  logic [WW-1:0]   word_reg, word_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CW-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic            busy_reg, busy_next;
  logic            trmt_reg, trmt_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic            load_byte;

  logic [IW-1:0]   arb_grant;
  logic            arb_valid;

  logic [WW-1:0]   req_words [NREQ];
  logic [WW-1:0]   src_word;
  logic [7:0]      src_bytes [NBYTES];

  genvar gi;
  for (gi = 0; gi < NREQ; gi++) begin : g_words
    assign req_words[gi] = req_data[gi*WW +: WW];
  end

  // At grant the word register is not yet loaded, so the first byte is taken
  // straight from the winning requester's input word.
  assign src_word = (state_reg == IDLE) ? req_words[arb_grant] : word_reg;

  for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
    assign src_bytes[gi] = src_word[gi*8 +: 8];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      byte_cnt_reg <= '0;
      ack_reg      <= '0;
      busy_reg     <= 1'b0;
      trmt_reg     <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      byte_cnt_reg <= byte_cnt_next;
      ack_reg      <= ack_next;
      busy_reg     <= busy_next;
      trmt_reg     <= trmt_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  // Outputs are registered: trmt/tx_data are prepared on the transition into
  // LOAD so they are high/valid exactly during the LOAD cycle; ack likewise
  // during the ACK cycle.
  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    byte_cnt_next = byte_cnt_reg;
    ack_next      = '0;
    busy_next     = busy_reg;
    trmt_next     = 1'b0;
    tx_data_next  = tx_data_reg;
    load_byte     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          word_next     = src_word;
          grant_next    = arb_grant;
          byte_cnt_next = CW'(NBYTES - 1);
          busy_next     = 1'b1;
          load_byte     = 1'b1;
          state_next    = LOAD;
        end
      end
      LOAD: begin
        state_next = WAIT;
      end
      WAIT: begin
        // tx_done is cleared by the time WAIT is entered, so any high level
        // seen here belongs to the byte just launched.
        if (tx_done) begin
          if (byte_cnt_reg != '0) begin
            byte_cnt_next = byte_cnt_reg - CW'(1);
            load_byte     = 1'b1;
            state_next    = LOAD;
          end else begin
            ack_next   = NREQ'(1) << grant_reg;
            state_next = ACK;
          end
        end
      end
      ACK: begin
        busy_next   = 1'b0;
        rr_ptr_next = (grant_reg == IW'(NREQ - 1)) ? '0 : grant_reg + IW'(1);
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (load_byte) begin
      trmt_next    = 1'b1;
      tx_data_next = src_bytes[byte_cnt_next];
    end
  end

  assign ack     = ack_reg;
  assign busy    = busy_reg;
  assign trmt    = trmt_reg;
  assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NREQ=2, NBYTES=2).
// The transmitter model raises tx_done 50 cycles after trmt, keeps it high
// (stale) until the next trmt, and comes out of reset with tx_done high.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NREQ   = 2;
  localparam int NBYTES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  ack;
  logic        busy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .tx_done  (tx_done)
  );

  int tx_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done <= 1'b1;
      tx_cnt  <= 0;
    end else if (trmt) begin
      tx_done <= 1'b0;
      tx_cnt  <= 50;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_done <= 1'b1;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] byte_q[$];
  int         ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Logs bytes and acks, drops each requester's req on its ack, and returns
  // once nothing is requested and the scheduler is idle.
  task automatic run_xfer(input int budget, output logic timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while ((req != '0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
      if (trmt) byte_q.push_back(tx_data);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          ack_q.push_back(i);
          req[i] = 1'b0;
        end
      end
    end
    if (n >= budget) timeout = 1'b1;
  endtask

  task automatic check_bytes(input string name, input int nexp, input logic [31:0] exp);
    logic [31:0] act;
    check({name, "_nbytes"}, 32'(byte_q.size()), 32'(nexp));
    for (int j = 0; j < nexp; j++) begin
      act = (j < byte_q.size()) ? 32'(byte_q[j]) : 32'hFFFF_FFFF;
      check($sformatf("%s_byte%0d", name, j), act, 32'(exp[31-8*j -: 8]));
    end
  endtask

  typedef struct {
    logic        do_reset;
    logic [1:0]  req;
    logic [15:0] w0;
    logic [15:0] w1;
    int          nbytes;
    logic [31:0] exp_bytes;   // first transmitted byte in [31:24]
    int          nack;
    int          ack_first;
    int          ack_second;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic to;
    int   n;
    logic [31:0] act;

    // Round-robin state carries from one vector to the next.
    vecs[0] = '{1'b1, 2'b01, {8'h12, POS_ACK}, 16'h0000, 2, 32'h12A5_0000, 1, 0, 0};
    vecs[1] = '{1'b1, 2'b11, 16'hAAAA, 16'h5555, 4, 32'hAAAA_5555, 2, 0, 1};
    vecs[2] = '{1'b0, 2'b01, 16'hAAAA, 16'h5555, 2, 32'hAAAA_0000, 1, 0, 0};
    vecs[3] = '{1'b0, 2'b11, 16'hAAAA, 16'h5555, 4, 32'h5555_AAAA, 2, 1, 0};
    vecs[4] = '{1'b0, 2'b10, 16'h0000, 16'hBEEF, 2, 32'hBEEF_0000, 1, 1, 0};
    vecs[5] = '{1'b0, 2'b11, 16'h0102, 16'h0304, 4, 32'h0102_0304, 2, 0, 1};

    // Reset values while reset is held.
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_trmt", 32'(trmt), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    rst_n = 1'b1;
    // tx_done is high with nothing requested: the scheduler must stay idle.
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_trmt", 32'(trmt), 32'h0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_reset) apply_reset();
      byte_q.delete();
      ack_q.delete();
      req_data = {vecs[v].w1, vecs[v].w0};
      req      = vecs[v].req;
      run_xfer(2000, to);
      check($sformatf("vec%0d_timeout", v), 32'(to), 32'h0);
      check_bytes($sformatf("vec%0d", v), vecs[v].nbytes, vecs[v].exp_bytes);
      check($sformatf("vec%0d_nack", v), 32'(ack_q.size()), 32'(vecs[v].nack));
      act = (ack_q.size() > 0) ? 32'(ack_q[0]) : 32'hFFFF_FFFF;
      check($sformatf("vec%0d_ack0", v), act, 32'(vecs[v].ack_first));
      if (vecs[v].nack > 1) begin
        act = (ack_q.size() > 1) ? 32'(ack_q[1]) : 32'hFFFF_FFFF;
        check($sformatf("vec%0d_ack1", v), act, 32'(vecs[v].ack_second));
      end
      $display("vec%0d: req=%b bytes=%0d acks=%0d", v, vecs[v].req, byte_q.size(), ack_q.size());
    end

    // Data change one cycle after grant must not affect the word in flight.
    apply_reset();
    byte_q.delete();
    ack_q.delete();
    req_data = {16'h0000, 16'h12A5};
    req      = 2'b01;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("chg_grant_seen", 32'(busy), 32'h1);
    if (trmt) byte_q.push_back(tx_data);
    req_data = {16'h0000, 16'hFFFF};
    run_xfer(2000, to);
    check("chg_timeout", 32'(to), 32'h0);
    check_bytes("chg", 2, 32'h12A5_0000);
    check("chg_nack", 32'(ack_q.size()), 32'h1);
    $display("data_change: bytes=%0d acks=%0d", byte_q.size(), ack_q.size());

    // Reset in the WAIT of the first byte abandons the word; it restarts.
    apply_reset();
    req_data = {16'h0000, 16'h12A5};
    req      = 2'b01;
    n = 0;
    while (!trmt && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_first_trmt", 32'(tx_data), 32'h12);
    repeat (5) @(negedge clk);
    check("mid_busy_in_wait", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_trmt", 32'(trmt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_trmt_held", 32'(trmt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    byte_q.delete();
    ack_q.delete();
    run_xfer(2000, to);
    check("mid_timeout", 32'(to), 32'h0);
    check_bytes("mid_restart", 2, 32'h12A5_0000);
    check("mid_nack", 32'(ack_q.size()), 32'h1);
    $display("reset_mid_word: bytes=%0d acks=%0d", byte_q.size(), ack_q.size());

    // Back-to-back: req0 held through ack triggers a second transfer.
    apply_reset();
    req_data = {16'h0000, 16'h1234};
    req      = 2'b01;
    n = 0;
    while (ack != 2'b01 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_ack", 32'(ack), 32'h1);
    @(negedge clk);
    check("b2b_ack_one_cycle", 32'(ack), 32'h0);
    check("b2b_busy_gap", 32'(busy), 32'h0);
    check("b2b_gap_no_trmt", 32'(trmt), 32'h0);
    @(negedge clk);
    check("b2b_busy_again", 32'(busy), 32'h1);
    check("b2b_trmt_again", 32'(trmt), 32'h1);
    check("b2b_tx_data", 32'(tx_data), 32'h12);
    byte_q.delete();
    ack_q.delete();
    byte_q.push_back(tx_data);
    run_xfer(2000, to);
    check("b2b_timeout", 32'(to), 32'h0);
    check_bytes("b2b_second", 2, 32'h1234_0000);
    repeat (5) @(negedge clk);
    check("b2b_final_idle", 32'(busy), 32'h0);
    $display("back_to_back: bytes=%0d acks=%0d", byte_q.size(), ack_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
